// File: rtl/lights_onchip_mem_initiator.sv
// Avalon-MM initiator for the lights on-chip RAM: fills a region with seed+i,
// reads it back through a latency-matched check pipeline and reports mismatches.
module lights_onchip_mem_initiator #(
    parameter int ADDR_W       = 10,
    parameter int DATA_W       = 32,
    parameter int READ_LATENCY = 1
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [ADDR_W:0]     length,
    input  logic [DATA_W-1:0]   seed,
    input  logic                hold,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ADDR_W:0]     error_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    output logic [ADDR_W-1:0]   m_address,
    output logic [DATA_W/8-1:0] m_byteenable,
    output logic                m_chipselect,
    output logic                m_write,
    output logic [DATA_W-1:0]   m_writedata,
    output logic                m_clken,
    input  logic [DATA_W-1:0]   m_readdata
);
    localparam int LEN_W   = ADDR_W + 1;
    localparam int DRAIN_W = $clog2(READ_LATENCY + 1);
    localparam logic [LEN_W-1:0] MAX_LEN = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {IDLE, WRITE, READ, DRAIN, FINISH} state_t;

    state_t               state;
    logic                 check_after_write;
    logic [ADDR_W-1:0]    cmd_base;
    logic [DATA_W-1:0]    cmd_seed;
    logic [LEN_W-1:0]     last_idx;
    logic [LEN_W-1:0]     idx;
    logic [LEN_W-1:0]     n_sat;
    logic [DRAIN_W-1:0]   drain_cnt;
    logic                 pipe_valid [READ_LATENCY];
    logic [DATA_W-1:0]    pipe_data  [READ_LATENCY];
    logic [ADDR_W-1:0]    pipe_addr  [READ_LATENCY];
    logic                 mismatch;
    logic                 advance;

    // The RAM shares the freeze, so in-flight reads stay aligned with pipe_*.
    assign m_clken = reset | ~hold;

    // IDLE and FINISH touch no RAM state, so start is accepted and done stays one cycle under hold.
    assign advance = ~hold | (state == IDLE) | (state == FINISH);

    always_comb begin
        n_sat    = (length > MAX_LEN) ? MAX_LEN : length;
        mismatch = pipe_valid[READ_LATENCY-1] && (m_readdata != pipe_data[READ_LATENCY-1]);
    end

    // During READ m_writedata carries the expected word so the pipeline can capture it.
    always_ff @(posedge clk) begin
        if (reset) begin
            state             <= IDLE;
            busy              <= 1'b0;
            done              <= 1'b0;
            pass              <= 1'b0;
            error_count       <= '0;
            first_err_addr    <= '0;
            m_address         <= '0;
            m_byteenable      <= '0;
            m_chipselect      <= 1'b0;
            m_write           <= 1'b0;
            m_writedata       <= '0;
            check_after_write <= 1'b0;
            cmd_base          <= '0;
            cmd_seed          <= '0;
            last_idx          <= '0;
            idx               <= '0;
            drain_cnt         <= '0;
            for (int s = 0; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= 1'b0;
                pipe_data[s]  <= '0;
                pipe_addr[s]  <= '0;
            end
        end else if (advance) begin
            pipe_valid[0] <= (state == READ);
            pipe_data[0]  <= m_writedata;
            pipe_addr[0]  <= m_address;
            for (int s = 1; s < READ_LATENCY; s++) begin
                pipe_valid[s] <= pipe_valid[s-1];
                pipe_data[s]  <= pipe_data[s-1];
                pipe_addr[s]  <= pipe_addr[s-1];
            end
            if (mismatch) begin
                error_count <= error_count + 1'b1;
                if (error_count == '0) begin
                    first_err_addr <= pipe_addr[READ_LATENCY-1];
                end
            end
            done <= 1'b0;

            case (state)
                IDLE: begin
                    if (start && length == '0) begin
                        state          <= FINISH;
                        done           <= 1'b1;
                        pass           <= 1'b1;
                        error_count    <= '0;
                        first_err_addr <= '0;
                    end else if (start) begin
                        check_after_write <= (mode != 2'b01);
                        cmd_base          <= base_addr;
                        cmd_seed          <= seed;
                        last_idx          <= n_sat - 1'b1;
                        idx               <= '0;
                        error_count       <= '0;
                        first_err_addr    <= '0;
                        pass              <= 1'b0;
                        busy              <= 1'b1;
                        m_address         <= base_addr;
                        m_writedata       <= seed;
                        m_chipselect      <= 1'b1;
                        m_byteenable      <= '1;
                        m_write           <= (mode != 2'b10);
                        state             <= (mode == 2'b10) ? READ : WRITE;
                    end
                end
                WRITE: begin
                    if (idx == last_idx) begin
                        idx     <= '0;
                        m_write <= 1'b0;
                        if (check_after_write) begin
                            state       <= READ;
                            m_address   <= cmd_base;
                            m_writedata <= cmd_seed;
                        end else begin
                            state        <= FINISH;
                            done         <= 1'b1;
                            busy         <= 1'b0;
                            pass         <= 1'b1;
                            m_chipselect <= 1'b0;
                            m_byteenable <= '0;
                        end
                    end else begin
                        idx         <= idx + 1'b1;
                        m_address   <= m_address + 1'b1;
                        m_writedata <= m_writedata + 1'b1;
                    end
                end
                READ: begin
                    if (idx == last_idx) begin
                        state        <= DRAIN;
                        drain_cnt    <= '0;
                        m_chipselect <= 1'b0;
                        m_byteenable <= '0;
                    end else begin
                        idx         <= idx + 1'b1;
                        m_address   <= m_address + 1'b1;
                        m_writedata <= m_writedata + 1'b1;
                    end
                end
                DRAIN: begin
                    // The last read's comparison lands on this same edge, hence the mismatch term.
                    if (drain_cnt == DRAIN_W'(READ_LATENCY - 1)) begin
                        state <= FINISH;
                        done  <= 1'b1;
                        busy  <= 1'b0;
                        pass  <= (error_count == '0) && !mismatch;
                    end else begin
                        drain_cnt <= drain_cnt + 1'b1;
                    end
                end
                FINISH: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_lights_onchip_mem_initiator.sv
// Directed bench: two initiators (read latency 1 and 2) share one command stream,
// each talking to its own RAM model with clken gating and optional word corruption.
module tb_lights_onchip_mem_initiator;
    typedef struct {
        logic        wr;
        logic [9:0]  addr;
        logic [31:0] data;
        int          off;
    } acc_t;

    logic        clk = 1'b0;
    logic        reset, start, hold;
    logic [1:0]  mode;
    logic [9:0]  base_addr;
    logic [10:0] length;
    logic [31:0] seed;

    logic        busy [2];
    logic        done [2];
    logic        pass [2];
    logic        m_chipselect [2];
    logic        m_write [2];
    logic        m_clken [2];
    logic [10:0] error_count [2];
    logic [9:0]  first_err_addr [2];
    logic [9:0]  m_address [2];
    logic [3:0]  m_byteenable [2];
    logic [31:0] m_writedata [2];
    logic [31:0] m_readdata [2];

    logic [31:0] mem [2][1024];
    logic [31:0] ram_s1 [2];
    logic [31:0] ram_s2 [2];
    logic        corrupt_on = 1'b0;
    logic [9:0]  corrupt_addr = 10'h0;

    int n_compared = 0;
    int n_mismatched = 0;
    int lat [2] = '{1, 2};
    int done_off [2];
    int clken_low [2];
    int busy_at1 [2];
    int busy_at_done [2];
    acc_t log0 [$];
    acc_t log1 [$];

    always #5 clk = ~clk;

    lights_onchip_mem_initiator #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(1)) dut1 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .length(length), .seed(seed), .hold(hold), .busy(busy[0]), .done(done[0]),
        .pass(pass[0]), .error_count(error_count[0]), .first_err_addr(first_err_addr[0]),
        .m_address(m_address[0]), .m_byteenable(m_byteenable[0]), .m_chipselect(m_chipselect[0]),
        .m_write(m_write[0]), .m_writedata(m_writedata[0]), .m_clken(m_clken[0]),
        .m_readdata(m_readdata[0])
    );

    lights_onchip_mem_initiator #(.ADDR_W(10), .DATA_W(32), .READ_LATENCY(2)) dut2 (
        .clk(clk), .reset(reset), .start(start), .mode(mode), .base_addr(base_addr),
        .length(length), .seed(seed), .hold(hold), .busy(busy[1]), .done(done[1]),
        .pass(pass[1]), .error_count(error_count[1]), .first_err_addr(first_err_addr[1]),
        .m_address(m_address[1]), .m_byteenable(m_byteenable[1]), .m_chipselect(m_chipselect[1]),
        .m_write(m_write[1]), .m_writedata(m_writedata[1]), .m_clken(m_clken[1]),
        .m_readdata(m_readdata[1])
    );

    // RAM models: registered output stages gated by clken; stage count sets the latency.
    always @(posedge clk) begin
        for (int j = 0; j < 2; j++) begin
            if (m_clken[j]) begin
                if (m_chipselect[j] && m_write[j]) mem[j][m_address[j]] <= m_writedata[j];
                ram_s1[j] <= mem[j][m_address[j]] ^
                             ((corrupt_on && m_address[j] == corrupt_addr) ? 32'h1 : 32'h0);
                ram_s2[j] <= ram_s1[j];
            end
        end
    end

    assign m_readdata[0] = ram_s1[0];
    assign m_readdata[1] = ram_s2[1];

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_compared++;
        if (got !== exp) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    function automatic acc_t getAcc(int j, int i);
        acc_t a;
        a = '{wr: 1'b0, addr: 10'h0, data: 32'h0, off: -1};
        if (j == 0 && i < log0.size()) a = log0[i];
        if (j == 1 && i < log1.size()) a = log1[i];
        return a;
    endfunction

    function automatic int countKind(int j, logic wr);
        int c = 0;
        int n = (j == 0) ? log0.size() : log1.size();
        for (int i = 0; i < n; i++) if (getAcc(j, i).wr == wr) c++;
        return c;
    endfunction

    // Issues one command, scrambles the command inputs after acceptance, optionally
    // holds and re-pulses start, and logs every RAM access each instance makes.
    task automatic applyStimulus(input logic [1:0] m, input logic [9:0] b, input logic [10:0] n,
                                 input logic [31:0] s, input int hold_at, input int hold_len,
                                 input int glitch_at, input int budget);
        log0.delete();
        log1.delete();
        for (int j = 0; j < 2; j++) begin
            done_off[j] = -1; clken_low[j] = 0; busy_at1[j] = -1; busy_at_done[j] = -1;
        end
        @(negedge clk);
        start = 1'b1; mode = m; base_addr = b; length = n; seed = s;
        for (int off = 1; off <= budget; off++) begin
            @(negedge clk);
            start     = (off == glitch_at);
            mode      = ~m;
            base_addr = b ^ 10'h155;
            length    = 11'd3;
            seed      = ~s;
            hold      = (off >= hold_at) && (off < hold_at + hold_len);
            #1;
            for (int j = 0; j < 2; j++) begin
                if (m_chipselect[j] && m_clken[j]) begin
                    if (j == 0) log0.push_back('{m_write[j], m_address[j], m_writedata[j], off});
                    else        log1.push_back('{m_write[j], m_address[j], m_writedata[j], off});
                end
                if (!m_clken[j]) clken_low[j]++;
                if (off == 1) busy_at1[j] = int'(busy[j]);
                if (done[j] && done_off[j] < 0) begin
                    done_off[j] = off;
                    busy_at_done[j] = int'(busy[j]);
                end
            end
            if (done_off[0] >= 0 && done_off[1] >= 0) break;
        end
        start = 1'b0;
        hold  = 1'b0;
        @(negedge clk);
        #1;
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("done_seen[%0d]", j), done_off[j] >= 0, 1'b1);
            checkOutput($sformatf("done_one_cycle[%0d]", j), done[j], 1'b0);
        end
    endtask

    task automatic checkResult(input string tag, input logic p, input int errs, input logic [9:0] fa);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("%s pass[%0d]", tag, j), pass[j], p);
            checkOutput($sformatf("%s error_count[%0d]", tag, j), error_count[j], errs);
            checkOutput($sformatf("%s first_err_addr[%0d]", tag, j), first_err_addr[j], fa);
        end
    endtask

    task automatic checkIdleOutputs(input string tag);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("%s busy[%0d]", tag, j), busy[j], 1'b0);
            checkOutput($sformatf("%s done[%0d]", tag, j), done[j], 1'b0);
            checkOutput($sformatf("%s pass[%0d]", tag, j), pass[j], 1'b0);
            checkOutput($sformatf("%s error_count[%0d]", tag, j), error_count[j], 0);
            checkOutput($sformatf("%s first_err_addr[%0d]", tag, j), first_err_addr[j], 0);
            checkOutput($sformatf("%s chipselect[%0d]", tag, j), m_chipselect[j], 1'b0);
            checkOutput($sformatf("%s write[%0d]", tag, j), m_write[j], 1'b0);
            checkOutput($sformatf("%s address[%0d]", tag, j), m_address[j], 0);
            checkOutput($sformatf("%s writedata[%0d]", tag, j), m_writedata[j], 0);
            checkOutput($sformatf("%s byteenable[%0d]", tag, j), m_byteenable[j], 0);
            checkOutput($sformatf("%s clken[%0d]", tag, j), m_clken[j], 1'b1);
        end
    endtask

    initial begin
        acc_t a;
        int   no_done;
        reset = 1'b1; start = 1'b0; hold = 1'b0; mode = 2'b00;
        base_addr = '0; length = '0; seed = '0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
        #1;
        checkIdleOutputs("reset");

        // Fill+check, base 0x010, N=4
        applyStimulus(2'b00, 10'h010, 11'd4, 32'hA5A5_0000, 0, 0, 0, 100);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t1 done_off[%0d]", j), done_off[j], 2 * 4 + lat[j] + 1);
            checkOutput($sformatf("t1 busy_at1[%0d]", j), busy_at1[j], 1);
            checkOutput($sformatf("t1 busy_at_done[%0d]", j), busy_at_done[j], 0);
            checkOutput($sformatf("t1 nacc[%0d]", j), (j == 0) ? log0.size() : log1.size(), 8);
            for (int i = 0; i < 4; i++) begin
                a = getAcc(j, i);
                checkOutput($sformatf("t1 wr%0d addr[%0d]", i, j), a.addr, 10'h010 + i);
                checkOutput($sformatf("t1 wr%0d data[%0d]", i, j), a.data, 32'hA5A5_0000 + i);
                checkOutput($sformatf("t1 wr%0d off[%0d]", i, j), a.off, i + 1);
                checkOutput($sformatf("t1 wr%0d strobe[%0d]", i, j), a.wr, 1'b1);
                a = getAcc(j, i + 4);
                checkOutput($sformatf("t1 rd%0d addr[%0d]", i, j), a.addr, 10'h010 + i);
                checkOutput($sformatf("t1 rd%0d off[%0d]", i, j), a.off, i + 5);
            end
            checkOutput($sformatf("t1 mem012[%0d]", j), mem[j][10'h012], 32'hA5A5_0002);
        end
        checkResult("t1", 1'b1, 0, 10'h0);

        // Same command with the word at 0x012 corrupted on read
        corrupt_on = 1'b1; corrupt_addr = 10'h012;
        applyStimulus(2'b00, 10'h010, 11'd4, 32'hA5A5_0000, 0, 0, 0, 100);
        corrupt_on = 1'b0;
        for (int j = 0; j < 2; j++)
            checkOutput($sformatf("t2 done_off[%0d]", j), done_off[j], 2 * 4 + lat[j] + 1);
        checkResult("t2", 1'b0, 1, 10'h012);

        // Wrap-around fill only, then check only with matching and wrong seed
        applyStimulus(2'b01, 10'h3FE, 11'd4, 32'h1234_5678, 0, 0, 0, 100);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t3 done_off[%0d]", j), done_off[j], 5);
            checkOutput($sformatf("t3 writes[%0d]", j), countKind(j, 1'b1), 4);
            for (int i = 0; i < 4; i++)
                checkOutput($sformatf("t3 wr%0d addr[%0d]", i, j), getAcc(j, i).addr, 10'(10'h3FE + i));
        end
        checkResult("t3", 1'b1, 0, 10'h0);
        applyStimulus(2'b10, 10'h3FE, 11'd4, 32'h1234_5678, 0, 0, 0, 100);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t3c done_off[%0d]", j), done_off[j], 4 + lat[j] + 1);
            checkOutput($sformatf("t3c reads[%0d]", j), countKind(j, 1'b0), 4);
            checkOutput($sformatf("t3c writes[%0d]", j), countKind(j, 1'b1), 0);
        end
        checkResult("t3c", 1'b1, 0, 10'h0);
        applyStimulus(2'b10, 10'h3FE, 11'd4, 32'h1234_5679, 0, 0, 0, 100);
        checkResult("t3e", 1'b0, 4, 10'h3FE);

        // N=0 finishes at once with no bus activity
        applyStimulus(2'b00, 10'h020, 11'd0, 32'h0, 0, 0, 0, 20);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t5 done_off[%0d]", j), done_off[j], 1);
            checkOutput($sformatf("t5 nacc[%0d]", j), (j == 0) ? log0.size() : log1.size(), 0);
        end
        checkResult("t5", 1'b1, 0, 10'h0);

        // Hold for 3 cycles in the middle of READ
        applyStimulus(2'b00, 10'h040, 11'd6, 32'hDEAD_0000, 8, 3, 0, 100);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t4 done_off[%0d]", j), done_off[j], 2 * 6 + lat[j] + 1 + 3);
            checkOutput($sformatf("t4 clken_low[%0d]", j), clken_low[j], 3);
            checkOutput($sformatf("t4 reads[%0d]", j), countKind(j, 1'b0), 6);
            for (int i = 0; i < 6; i++)
                checkOutput($sformatf("t4 rd%0d addr[%0d]", i, j), getAcc(j, 6 + i).addr, 10'h040 + i);
        end
        checkResult("t4", 1'b1, 0, 10'h0);

        // N above 2**ADDR_W saturates to the full RAM
        applyStimulus(2'b00, 10'h005, 11'd2047, 32'h00C0_FFEE, 0, 0, 0, 2200);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t6 done_off[%0d]", j), done_off[j], 2 * 1024 + lat[j] + 1);
            checkOutput($sformatf("t6 writes[%0d]", j), countKind(j, 1'b1), 1024);
            checkOutput($sformatf("t6 reads[%0d]", j), countKind(j, 1'b0), 1024);
            checkOutput($sformatf("t6 last_wr_addr[%0d]", j), getAcc(j, 1023).addr, 10'h004);
            checkOutput($sformatf("t6 last_wr_data[%0d]", j), getAcc(j, 1023).data, 32'h00C0_FFEE + 1023);
        end
        checkResult("t6", 1'b1, 0, 10'h0);

        // Reset during WRITE at i=2 aborts with no done pulse
        @(negedge clk);
        start = 1'b1; mode = 2'b00; base_addr = 10'h100; length = 11'd8; seed = 32'h0BAD_0000;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        #1;
        checkIdleOutputs("t7");
        reset = 1'b0;
        no_done = 0;
        for (int t = 0; t < 20; t++) begin
            @(negedge clk);
            #1;
            if (done[0] || done[1]) no_done++;
        end
        checkOutput("t7 no_done_after_reset", no_done, 0);

        // Normal run with a start pulse and changed inputs while busy
        applyStimulus(2'b00, 10'h200, 11'd5, 32'h5A5A_0000, 0, 0, 3, 100);
        for (int j = 0; j < 2; j++) begin
            checkOutput($sformatf("t8 done_off[%0d]", j), done_off[j], 2 * 5 + lat[j] + 1);
            checkOutput($sformatf("t8 nacc[%0d]", j), (j == 0) ? log0.size() : log1.size(), 10);
            checkOutput($sformatf("t8 first_addr[%0d]", j), getAcc(j, 0).addr, 10'h200);
            checkOutput($sformatf("t8 last_rd_addr[%0d]", j), getAcc(j, 9).addr, 10'h204);
            checkOutput($sformatf("t8 mem204[%0d]", j), mem[j][10'h204], 32'h5A5A_0004);
        end
        checkResult("t8", 1'b1, 0, 10'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end
endmodule
